ws2812b_frame_sequencer: RTL
============================

// Module: ws2812b_frame_sequencer
// PURPOSE
//  Frame-level controller for the ws2812b serializer. Holds a NUM_PIXELS x 24-bit GRB pixel buffer
//  written by the peripheral register block and streams pixels 0..length-1 over the serializer's
//  valid/ready handshake, asserting latch with the last pixel. Sits between the register decode and the ws2812b core.
//  Frames start on a software pulse or an optional periodic auto-refresh timer.
// PARAMETERS
//  NUM_PIXELS  64   pixel buffer depth (power of two)
//  ADDR_W      6    log2(NUM_PIXELS)
//  PRESCALE    64   clk cycles per refresh tick (1 us at 64 MHz)
// PORTS
//  clk         in   1       clock
//  reset       in   1       asynchronous, active-high reset
//  wr_en       in   1       pixel buffer write strobe
//  wr_addr     in   ADDR_W  pixel index to write
//  wr_data     in   24      {G,R,B} pixel value
//  start       in   1       one-cycle frame start request
//  length      in   ADDR_W+1 pixels per frame, 0..NUM_PIXELS; sampled at frame start
//  latch_en    in   1       assert px_latch with last pixel; sampled at frame start
//  auto_en     in   1       enable periodic refresh
//  period      in   16      refresh period in ticks; 0 = auto-refresh disabled
//  px_data     out  24      pixel to serializer
//  px_valid    out  1       px_data/px_latch valid
//  px_latch    out  1       current pixel is last; serializer latches after it
//  px_ready    in   1       serializer can accept a pixel
//  busy        out  1       frame in progress (state != IDLE)
//  frame_done  out  1       one-cycle pulse at end of each frame
//  overrun     out  1       sticky: start arrived while busy and a start already pending; cleared on reset only
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending=0, tick/period counters 0. Buffer contents undefined.
//  Reset asserted mid-frame aborts immediately; px_valid drops asynchronously, no frame_done.
//  Buffer: 1 write port, 1 sync read port (1-cycle latency), read-first on same-address collision.
//   Writes allowed anytime; a pixel written before its LOAD cycle is sent with the new value.
//  Handshake: transfer when px_valid & px_ready in same cycle. px_valid, px_data, px_latch held
//   stable until transfer; px_valid low the cycle after transfer.
//  FSM:
//   IDLE  : on trigger (start | pending | auto_fire) -> capture length/latch_en, idx=0, clear pending.
//           if length==0 -> DONE, else -> LOAD.
//   LOAD  : issue buffer read at idx -> SEND (data valid entering SEND).
//   SEND  : px_valid=1, px_latch=latch_en & (idx==len-1). On transfer: last -> DRAIN, else idx++ -> LOAD.
//   DRAIN : wait for px_ready==1 (serializer finished last bit/latch) -> DONE.
//   DONE  : frame_done=1 for one cycle -> IDLE.
//  Per-pixel overhead: 2 cycles (LOAD+SEND) plus serializer wait; first px_valid 2 cycles after start.
//  length>NUM_PIXELS is clamped to NUM_PIXELS at capture.
//  start while busy: sets pending (1 deep); frame re-runs immediately after DONE. Second start while
//   pending already set -> overrun=1, request dropped. start in DONE cycle counts as busy.
//  Auto-refresh: prescaler counts 0..PRESCALE-1 continuously; tick at wrap. Period counter reloads
//   to period on each frame start and decrements on tick; at 0 with auto_en & period!=0 -> auto_fire.
//   auto_fire while busy sets pending (never overrun). Changing period takes effect at next reload.
//  Simultaneous start and auto_fire in IDLE: one frame, no pending.
// STRUCTURE
//  Shared package ws2812b_pkg: PIXEL_W=24, GRB field offsets, FSM state encoding (IDLE,LOAD,SEND,DRAIN,DONE).
//  One sub-module: ws2812b_pixel_ram (sync read, read-first, parameterised depth). Timer and FSM inline.
// TESTING
//  Write 3 pixels 0x0000FF,0x00FF00,0xFF0000; length=3, latch_en=1, start -> 3 transfers in order, latch only on 3rd, one frame_done.
//  Serializer model holds px_ready low 30 cycles per pixel -> px_data stable while valid, no drops or duplicates.
//  length=0, start -> no px_valid, frame_done 2 cycles after start.
//  start twice during frame -> exactly one extra frame, overrun=0; third start while pending -> overrun=1.
//  auto_en=1, period=5, PRESCALE=4 -> frame start every 20 clk, measured start-to-start.
//  Assert reset during SEND of pixel 1 -> px_valid=0 immediately, busy=0, no frame_done; new start works.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the ws2812b frame path: pixel format and sequencer states.
package ws2812b_pkg;

  localparam int PIXEL_W = 24;
  localparam int G_LSB   = 16;
  localparam int R_LSB   = 8;
  localparam int B_LSB   = 0;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic pixel_t grb(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    pixel_t p;
    p = '0;
    p[G_LSB +: 8] = g;
    p[R_LSB +: 8] = r;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Pixel buffer: one write port, one registered read port, read-first on address collision.
module ws2812b_pixel_ram
  import ws2812b_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem [DEPTH];
  pixel_t rd_data_q;

  // NOTE: the array and its read register carry no reset so the buffer maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Streams pixels 0..length-1 from the pixel buffer to the serializer, on software start or auto-refresh.
module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_W     = 6,
  parameter int PRESCALE   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              latch_en,
  input  logic              auto_en,
  input  logic [15:0]       period,
  output logic [23:0]       px_data,
  output logic              px_valid,
  output logic              px_latch,
  input  logic              px_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_PIXELS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              latch_q, latch_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              done_q;
  logic [PS_W-1:0]   presc_q;
  logic [15:0]       per_q;

  logic            rd_en;
  pixel_t          rd_data;
  logic            tick, auto_fire, trigger, frame_start, last;
  logic [ADDR_W:0] len_cap;

  ws2812b_pixel_ram #(.DEPTH(NUM_PIXELS), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  assign tick        = (presc_q == PS_W'(PRESCALE - 1));
  assign auto_fire   = auto_en & (period != '0) & (per_q == '0);
  assign trigger     = start | pending_q | auto_fire;
  assign frame_start = (state_q == ST_IDLE) & trigger;
  assign len_cap     = (length > MAX_LEN) ? MAX_LEN : length;
  assign last        = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    latch_d   = latch_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    rd_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (trigger) begin
        len_d     = len_cap;
        latch_d   = latch_en;
        idx_d     = '0;
        pending_d = 1'b0;
        state_d   = (len_cap == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        rd_en   = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (px_ready) begin
        if (last) state_d = ST_DRAIN;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: if (px_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Requests arriving mid-frame queue one deep; a second software start is dropped and flagged.
    if (state_q != ST_IDLE) begin
      if (start) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end
      if (auto_fire) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      latch_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      done_q    <= (state_q == ST_DONE);
    end
  end

  // Free-running prescaler; the period counter restarts from the live period at every frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      per_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (frame_start)              per_q <= period;
      else if (tick && per_q != '0) per_q <= per_q - 1'b1;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign px_valid   = (state_q == ST_SEND);
  assign px_latch   = px_valid & latch_q & last;
  assign px_data    = px_valid ? rd_data : '0;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule
